// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared widths and enums for the register-file write-port controller
package regfile_ctrl_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef enum logic {
        REQ_ALU,
        REQ_MEM
    } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter, grant bit 0 = ALU, bit 1 = MEM
module rr_arbiter2
    import regfile_ctrl_pkg::*;
(
    input  logic       req_alu,
    input  logic       req_mem,
    input  req_t       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        // On a tie the requester that did not win last time goes first
        if (req_alu && (!req_mem || last_grant == REQ_MEM)) begin
            grant = 2'b01;
        end else if (req_mem) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - register-file write-port controller: init sweep, writeback arbitration, hazard scoreboard
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid_i,
    input  logic [ADDR_W-1:0]   alu_dest_i,
    input  logic [DATA_W-1:0]   alu_data_i,
    output logic                alu_ready_o,
    input  logic                mem_valid_i,
    input  logic [ADDR_W-1:0]   mem_dest_i,
    input  logic [DATA_W-1:0]   mem_data_i,
    output logic                mem_ready_o,
    input  logic                issue_valid_i,
    input  logic [ADDR_W-1:0]   issue_dest_i,
    input  logic [ADDR_W-1:0]   src1_i,
    input  logic [ADDR_W-1:0]   src2_i,
    output logic                hazard_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                init_done_o,
    output logic                writeFlag_o,
    output logic [ADDR_W-1:0]   destReg_o,
    output logic [DATA_W-1:0]   data_o
);

    state_t              state;
    state_t              state_next;
    req_t                last_grant;
    logic [ADDR_W-1:0]   cnt;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                init_done;
    logic [1:0]          grant;
    logic                run;
    logic                accept;
    logic [ADDR_W-1:0]   wb_dest;

    assign run = (state == RUN);

    rr_arbiter2 u_arb (
        .req_alu    (alu_valid_i & run),
        .req_mem    (mem_valid_i & run),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Hazard looks only at registered busy bits; a writeback this cycle does not unblock it
    assign hazard_o = !run | busy[src1_i] | busy[src2_i] | (issue_valid_i & busy[issue_dest_i]);
    assign accept   = run & issue_valid_i & !hazard_o;
    assign wb_dest  = grant[1] ? mem_dest_i : alu_dest_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            cnt        <= '0;
            busy       <= '0;
            last_grant <= REQ_MEM;
            init_done  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                cnt <= cnt + ADDR_W'(1);
                if (state_next == RUN) begin
                    init_done <= 1'b1;
                end
            end else begin
                busy <= busy_next;
                if (grant[0]) begin
                    last_grant <= REQ_ALU;
                end else if (grant[1]) begin
                    last_grant <= REQ_MEM;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (cnt == ADDR_W'(NUM_REGS - 1)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // Clear first so that an accepted issue to the same register wins
    always_comb begin
        busy_next = busy;
        if (|grant) begin
            busy_next[wb_dest] = 1'b0;
        end
        if (accept) begin
            busy_next[issue_dest_i] = 1'b1;
        end
    end

    always_comb begin
        writeFlag_o = 1'b0;
        destReg_o   = '0;
        data_o      = '0;
        alu_ready_o = 1'b0;
        mem_ready_o = 1'b0;
        case (state)
            INIT: begin
                writeFlag_o = 1'b1;
                destReg_o   = cnt;
                data_o      = INIT_VALUE;
            end
            RUN: begin
                alu_ready_o = grant[0];
                mem_ready_o = grant[1];
                writeFlag_o = |grant;
                destReg_o   = wb_dest;
                data_o      = grant[1] ? mem_data_i : alu_data_i;
            end
            default: begin
                writeFlag_o = 1'b0;
            end
        endcase
    end

    assign busy_o      = busy;
    assign init_done_o = init_done;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - self-checking bench for regfile_ctrl against a behavioural model
module tb_regfile_ctrl;
    import regfile_ctrl_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                alu_valid, mem_valid, issue_valid;
    logic [ADDR_W-1:0]   alu_dest, mem_dest, issue_dest, src1, src2;
    logic [DATA_W-1:0]   alu_data, mem_data;
    logic                alu_ready, mem_ready, hazard, init_done, write_flag;
    logic [NUM_REGS-1:0] busy;
    logic [ADDR_W-1:0]   dest_reg;
    logic [DATA_W-1:0]   wdata;

    int errors = 0;
    int checks = 0;

    // Model state
    int  m_init_left;
    bit  m_busy [NUM_REGS];
    bit  m_alu_first;
    bit  m_done;

    // Expected outputs for the current cycle
    logic                e_wf, e_ar, e_mr, e_haz, e_done;
    logic [ADDR_W-1:0]   e_dest;
    logic [DATA_W-1:0]   e_data;
    logic [NUM_REGS-1:0] e_busy;

    always #5 clk = ~clk;

    regfile_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid_i   (alu_valid),
        .alu_dest_i    (alu_dest),
        .alu_data_i    (alu_data),
        .alu_ready_o   (alu_ready),
        .mem_valid_i   (mem_valid),
        .mem_dest_i    (mem_dest),
        .mem_data_i    (mem_data),
        .mem_ready_o   (mem_ready),
        .issue_valid_i (issue_valid),
        .issue_dest_i  (issue_dest),
        .src1_i        (src1),
        .src2_i        (src2),
        .hazard_o      (hazard),
        .busy_o        (busy),
        .init_done_o   (init_done),
        .writeFlag_o   (write_flag),
        .destReg_o     (dest_reg),
        .data_o        (wdata)
    );

    task automatic eval();
        @(negedge clk);
        for (int r = 0; r < NUM_REGS; r++) e_busy[r] = m_busy[r];
        e_done = m_done;
        if (m_init_left > 0) begin
            e_wf   = 1'b1;
            e_dest = ADDR_W'(NUM_REGS - m_init_left);
            e_data = 8'h00;
            e_ar   = 1'b0;
            e_mr   = 1'b0;
            e_haz  = 1'b1;
        end else begin
            e_ar   = alu_valid && (!mem_valid || m_alu_first);
            e_mr   = mem_valid && !e_ar;
            e_wf   = e_ar || e_mr;
            e_dest = e_mr ? mem_dest : alu_dest;
            e_data = e_mr ? mem_data : alu_data;
            e_haz  = m_busy[src1] || m_busy[src2] || (issue_valid && m_busy[issue_dest]);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_init_left = NUM_REGS;
            for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;
            m_alu_first = 1'b1;
            m_done      = 1'b0;
        end else if (m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0) m_done = 1'b1;
        end else begin
            if (e_ar) begin m_alu_first = 1'b0; m_busy[alu_dest] = 1'b0; end
            if (e_mr) begin m_alu_first = 1'b1; m_busy[mem_dest] = 1'b0; end
            if (issue_valid && !e_haz) m_busy[issue_dest] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        alu_dest = 0; mem_dest = 0; issue_dest = 0; src1 = 0; src2 = 0;
        alu_data = 0; mem_data = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
        for (int c = 0; c < NUM_REGS; c++) begin
            alu_valid = 1'($urandom); mem_valid = 1'($urandom); issue_valid = 1'($urandom);
            issue_dest = 3'($urandom);
            eval();
            checks++; if (write_flag !== 1'b1) begin errors++; $display("FAIL init_wf c=%0d got %0b exp 1", c, write_flag); end
            checks++; if (dest_reg !== 3'(c)) begin errors++; $display("FAIL init_dest got %0d exp %0d", dest_reg, c); end
            checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL init_data got %0h exp 00", wdata); end
            checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL init_ready got %0b%0b exp 00", alu_ready, mem_ready); end
            checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL init_hazard got %0b exp 1", hazard); end
            checks++; if (init_done !== 1'b0 || busy !== 8'h00) begin errors++; $display("FAIL init_state done=%0b busy=%0h exp 0/00", init_done, busy); end
            advance();
        end
        idle_inputs();
        eval();
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got %0b exp 1", init_done); end
        checks++; if (write_flag !== 1'b0) begin errors++; $display("FAIL run_idle_wf got %0b exp 0", write_flag); end
        advance();
    endtask

    task automatic test_round_robin();
        alu_valid = 1; alu_dest = 2; alu_data = 8'h11;
        mem_valid = 1; mem_dest = 5; mem_data = 8'h22;
        for (int c = 0; c < 6; c++) begin
            eval();
            checks++; if (alu_ready !== 1'(c % 2 == 0) || mem_ready !== 1'(c % 2 == 1)) begin errors++; $display("FAIL rr_grant c=%0d got %0b%0b exp alu=%0b", c, alu_ready, mem_ready, c % 2 == 0); end
            checks++; if (dest_reg !== e_dest || wdata !== e_data || write_flag !== 1'b1) begin errors++; $display("FAIL rr_port c=%0d got %0d/%0h exp %0d/%0h", c, dest_reg, wdata, e_dest, e_data); end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_dest = 3; src1 = 0; src2 = 1;
        eval();
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_issue_haz got %0b exp 0", hazard); end
        advance();
        issue_valid = 0; src1 = 3;
        eval();
        checks++; if (busy !== 8'h08) begin errors++; $display("FAIL sb_busy_set got %0h exp 08", busy); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_raw_haz got %0b exp 1", hazard); end
        advance();
        mem_valid = 1; mem_dest = 3; mem_data = 8'h5a;
        eval();
        checks++; if (mem_ready !== 1'b1 || dest_reg !== 3'd3 || wdata !== 8'h5a) begin errors++; $display("FAIL sb_wb got %0b/%0d/%0h exp 1/3/5a", mem_ready, dest_reg, wdata); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_no_bypass got %0b exp 1", hazard); end
        advance();
        mem_valid = 0;
        eval();
        checks++; if (busy !== 8'h00 || hazard !== 1'b0) begin errors++; $display("FAIL sb_clear busy=%0h haz=%0b exp 00/0", busy, hazard); end
        advance();
        idle_inputs();
    endtask

    task automatic test_waw();
        issue_valid = 1; issue_dest = 6;
        eval(); advance();
        eval();
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL waw_haz got %0b exp 1", hazard); end
        advance();
        alu_valid = 1; alu_dest = 6; alu_data = 8'h66;
        eval();
        checks++; if (busy !== 8'h40 || hazard !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL waw_hold busy=%0h haz=%0b rdy=%0b exp 40/1/1", busy, hazard, alu_ready); end
        advance();
        alu_valid = 0;
        eval();
        checks++; if (busy !== 8'h00 || hazard !== 1'b0) begin errors++; $display("FAIL waw_accept busy=%0h haz=%0b exp 00/0", busy, hazard); end
        advance();
        issue_valid = 0;
        eval();
        checks++; if (busy !== 8'h40) begin errors++; $display("FAIL waw_reset busy got %0h exp 40", busy); end
        advance();
        idle_inputs();
    endtask

    task automatic test_set_beats_clear();
        issue_valid = 1; issue_dest = 4;
        alu_valid = 1; alu_dest = 4; alu_data = 8'h44;
        eval();
        checks++; if (hazard !== 1'b0 || alu_ready !== 1'b1) begin errors++; $display("FAIL sbc_cycle haz=%0b rdy=%0b exp 0/1", hazard, alu_ready); end
        advance();
        idle_inputs();
        eval();
        checks++; if (busy[4] !== 1'b1 || busy !== e_busy) begin errors++; $display("FAIL sbc_busy got %0h exp %0h", busy, e_busy); end
        advance();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid && $urandom_range(0, 2) != 0) begin
                alu_valid = 1; alu_dest = 3'($urandom); alu_data = 8'($urandom);
            end
            if (!mem_valid && $urandom_range(0, 2) != 0) begin
                mem_valid = 1; mem_dest = 3'($urandom); mem_data = 8'($urandom);
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_dest = 3'($urandom); src1 = 3'($urandom); src2 = 3'($urandom);
            eval();
            checks++;
            if (alu_ready !== e_ar || mem_ready !== e_mr || write_flag !== e_wf || hazard !== e_haz
                || busy !== e_busy || init_done !== e_done
                || (e_wf && (dest_reg !== e_dest || wdata !== e_data))) begin
                errors++;
                $display("FAIL rand c=%0d got r=%0b%0b wf=%0b h=%0b b=%0h d=%0d/%0h exp r=%0b%0b wf=%0b h=%0b b=%0h d=%0d/%0h",
                         c, alu_ready, mem_ready, write_flag, hazard, busy, dest_reg, wdata,
                         e_ar, e_mr, e_wf, e_haz, e_busy, e_dest, e_data);
            end
            advance();
            if (e_ar) alu_valid = 0;
            if (e_mr) mem_valid = 0;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_run();
        for (int r = 0; r < NUM_REGS; r++) begin
            if (m_busy[r]) begin
                alu_valid = 1; alu_dest = 3'(r); alu_data = 8'(r);
                eval(); advance();
            end
        end
        idle_inputs();
        issue_valid = 1; issue_dest = 2; eval(); advance();
        issue_dest = 5; eval(); advance();
        issue_valid = 0;
        alu_valid = 1; alu_dest = 0; eval(); advance();
        alu_valid = 1; alu_dest = 1; alu_data = 8'h77;
        mem_valid = 1; mem_dest = 7; mem_data = 8'h88;
        eval();
        checks++; if (busy !== 8'h24) begin errors++; $display("FAIL mid_busy got %0h exp 24", busy); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL mid_pre_tie got mem_ready=%0b exp 1", mem_ready); end
        rst = 1'b1;
        advance();
        rst = 1'b0;
        eval();
        checks++; if (busy !== 8'h00 || alu_ready !== 1'b0 || mem_ready !== 1'b0 || dest_reg !== 3'd0) begin errors++; $display("FAIL mid_reset busy=%0h rdy=%0b%0b dest=%0d exp 00/00/0", busy, alu_ready, mem_ready, dest_reg); end
        checks++; if (init_done !== 1'b0 || hazard !== 1'b1) begin errors++; $display("FAIL mid_reset_init done=%0b haz=%0b exp 0/1", init_done, hazard); end
        advance();
        for (int c = 1; c < NUM_REGS; c++) begin eval(); advance(); end
        eval();
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0 || dest_reg !== 3'd1 || wdata !== 8'h77) begin errors++; $display("FAIL mid_first_tie got %0b%0b %0d/%0h exp alu 1/77", alu_ready, mem_ready, dest_reg, wdata); end
        advance();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_scoreboard();
        test_waw();
        test_set_beats_clear();
        test_random();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
Write-port controller for the 8x8-bit register file. After reset it runs an init sequence that writes a known value into every register. It then shares the single register-file write port between the ALU and memory writeback requesters, using round-robin arbitration with valid/ready handshakes. A pending-write scoreboard gives the issue stage a read-after-write / write-after-write hazard stall.

Parameters:
DATA_W, 8, register data width
ADDR_W, 3, register index width
NUM_REGS, 8, number of registers (2**ADDR_W)
INIT_VALUE, 8'h00, value written to every register during INIT

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
alu_valid_i  in  1  ALU writeback request
alu_dest_i  in  ADDR_W  ALU destination register
alu_data_i  in  DATA_W  ALU writeback data
alu_ready_o  out  1  ALU request granted this cycle
mem_valid_i  in  1  memory writeback request
mem_dest_i  in  ADDR_W  memory destination register
mem_data_i  in  DATA_W  memory writeback data
mem_ready_o  out  1  memory request granted this cycle
issue_valid_i  in  1  issue stage dispatching an instruction that will write issue_dest_i
issue_dest_i  in  ADDR_W  destination of the issuing instruction
src1_i  in  ADDR_W  first source register of the issuing instruction
src2_i  in  ADDR_W  second source register of the issuing instruction
hazard_o  out  1  stall: issue is not accepted this cycle
busy_o  out  NUM_REGS  scoreboard, bit r = write to r outstanding
init_done_o  out  1  high once INIT has completed
writeFlag_o  out  1  to register file write enable
destReg_o  out  ADDR_W  to register file write index
data_o  out  DATA_W  to register file write data

Behaviour:
- States: INIT, RUN. rst forces INIT from any state, including mid-transfer.
- Values on rst: cnt=0, busy=0, last_grant=MEM (ALU wins the first tie), init_done_o=0.
- INIT:
  - writeFlag_o=1, destReg_o=cnt, data_o=INIT_VALUE every cycle.
  - cnt increments each cycle; at cnt==NUM_REGS-1 the next state is RUN. INIT lasts exactly NUM_REGS cycles.
  - alu_ready_o=0, mem_ready_o=0, hazard_o=1. Issue requests are ignored.
- RUN: init_done_o=1 (registered; rises on the first RUN cycle).
- Arbitration (combinational, RUN only):
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - Neither valid: no grant, writeFlag_o=0.
  - A transfer is a grant: granted ready_o=1; writeFlag_o=1; destReg_o/data_o taken from the granted requester.
  - last_grant updates only on a transfer.
  - ready_o may depend on valid_i. Requesters hold valid, dest and data stable until ready is seen, and must not make valid depend on ready.
  - Write latency: the register file shows new data on the cycle after the transfer.
- Scoreboard (RUN only):
  - hazard_o = INIT | busy[src1_i] | busy[src2_i] | (issue_valid_i & busy[issue_dest_i]).
  - hazard_o uses registered busy bits only; there is no same-cycle bypass.
  - Issue accepted = issue_valid_i & !hazard_o. On acceptance busy[issue_dest_i] is set next cycle.
  - A transfer to register r clears busy[r] next cycle.
  - Accepted issue and writeback to the same r in one cycle: set wins, busy[r]=1.
  - A writeback to a non-busy register writes normally; busy is unchanged.
- hazard_o depends on src1_i/src2_i even when issue_valid_i=0. The issue stage qualifies it with its own valid.
- busy_o is a direct register output.

Decomposition:
- Package regfile_ctrl_pkg:
  - DATA_W, ADDR_W and NUM_REGS constants
  - state_t enum {INIT, RUN}
  - req_t enum {REQ_ALU, REQ_MEM}
- One sub-module, rr_arbiter2:
  - inputs: two requests, last_grant
  - outputs: one-hot grant
  - purely combinational; last_grant is held in the parent.
- Scoreboard, INIT counter and port muxing stay in regfile_ctrl.

Test Plan:
- Reset/INIT: rst high 2 cycles then low -> next 8 cycles writeFlag_o=1, destReg_o=0..7, data_o=8'h00; init_done_o=1 from cycle 8; both ready=0 and hazard_o=1 throughout INIT.
- Round-robin: in RUN hold alu(dest=2, data=8'h11) and mem(dest=5, data=8'h22) valid -> cycle 0 alu_ready_o=1, destReg_o=2, data_o=8'h11; cycle 1 mem_ready_o=1, destReg_o=5, data_o=8'h22; grants alternate while both are held.
- Scoreboard: issue dest=3 with src 0/1 -> busy_o=8'h08 next cycle; src1_i=3 -> hazard_o=1; mem writeback dest=3 -> busy_o=8'h00 the cycle after, hazard_o=0.
- Write-after-write block: busy[6]=1, issue_valid_i=1 with issue_dest_i=6 -> hazard_o=1, busy_o unchanged; after ALU writeback to 6 the issue is accepted and busy[6] is set again.
- Set beats clear: busy[4]=0, same cycle accepted issue dest=4 and alu writeback dest=4 -> busy[4]=1 next cycle.
- Reset mid-run: busy_o=8'h24 and both requesters valid, assert rst for 1 cycle -> busy_o=0, readies 0, INIT restarts at destReg_o=0; first tie after INIT is granted to ALU.
